// File: rtl/ex_div_ctrl.sv
// Purpose: multi-cycle restoring divide sequencer for the EX stage (div/divu), result to the EX mux.
// Latency: accept cycle + DATA_SIZE BUSY cycles, result in DONE; a zero divisor skips straight to DONE.
// Backpressure: stalls EX through div_stall_c while working; waits in DONE while mem_stall_c is high.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   div_start, div_signed   request from EX and signedness (sampled with div_start in IDLE)
//   div_a, div_b            forwarded dividend / divisor
//   flush_c                 branch/jump flush; kills any in-flight divide
//   mem_stall_c             downstream stall; holds the result in DONE
//   div_stall_c             stall request OR'd into ex_stall_c
//   div_done                result valid this cycle
//   div_quot, div_rem       quotient (LO) and remainder (HI)
//   div_by_zero             divisor was zero, qualified by div_done
module ex_div_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_W     = $clog2(DATA_SIZE + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [DATA_SIZE-1:0] div_a,
  input  logic [DATA_SIZE-1:0] div_b,
  input  logic                 flush_c,
  input  logic                 mem_stall_c,
  output logic                 div_stall_c,
  output logic                 div_done,
  output logic [DATA_SIZE-1:0] div_quot,
  output logic [DATA_SIZE-1:0] div_rem,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_SIZE-1:0] abs_b;
  logic [DATA_SIZE-1:0] rem_r;
  logic [DATA_SIZE-1:0] quot_r;
  logic                 sign_q;
  logic                 sign_r;

  // Operand magnitudes; divu never negates.
  logic                 a_neg;
  logic                 b_neg;
  logic [DATA_SIZE-1:0] abs_a_in;
  logic [DATA_SIZE-1:0] abs_b_in;
  logic                 b_zero;
  logic                 accept;

  assign a_neg    = div_signed & div_a[DATA_SIZE-1];
  assign b_neg    = div_signed & div_b[DATA_SIZE-1];
  assign abs_a_in = a_neg ? -div_a : div_a;
  assign abs_b_in = b_neg ? -div_b : div_b;
  assign b_zero   = (div_b == '0);
  assign accept   = (state == IDLE) & div_start & ~flush_c;

  // One restoring step. The shifted remainder is one bit wider than the
  // operands because the remainder can be as large as a full-width divisor
  // minus one; the subtraction result itself always fits DATA_SIZE bits
  // whenever it is kept.
  logic [DATA_SIZE:0]   rem_shift;
  logic                 trial_ok;
  logic [DATA_SIZE-1:0] trial;
  logic [DATA_SIZE-1:0] rem_nxt;
  logic [DATA_SIZE-1:0] quot_nxt;
  logic                 last_iter;

  assign rem_shift = {rem_r, quot_r[DATA_SIZE-1]};
  assign trial_ok  = (rem_shift >= {1'b0, abs_b});
  assign trial     = rem_shift[DATA_SIZE-1:0] - abs_b;
  assign rem_nxt   = trial_ok ? trial : rem_shift[DATA_SIZE-1:0];
  assign quot_nxt  = {quot_r[DATA_SIZE-2:0], trial_ok};
  assign last_iter = (cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins in every state.
  always_comb begin
    state_nxt = state;
    if (flush_c) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            state_nxt = b_zero ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (last_iter) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          // div_start is ignored here: the same instruction is still in ID_EX.
          if (!mem_stall_c) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs. Stall is masked by flush so the killed instruction releases EX
  // in the same cycle the redirect is seen.
  always_comb begin
    div_done    = (state == DONE);
    div_stall_c = 1'b0;
    if (!flush_c) begin
      div_stall_c = accept | (state == BUSY) | ((state == DONE) & mem_stall_c);
    end
  end

  // Datapath and registered results. Sign fixup is applied on the edge that
  // enters DONE, so results are stable for the whole DONE residency.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt         <= '0;
      abs_b       <= '0;
      rem_r       <= '0;
      quot_r      <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_quot    <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
    end else if (flush_c) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            abs_b  <= abs_b_in;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            if (b_zero) begin
              cnt         <= '0;
              div_quot    <= '1;
              div_rem     <= div_a;
              div_by_zero <= 1'b1;
            end else begin
              cnt    <= CNT_W'(DATA_SIZE);
              rem_r  <= '0;
              quot_r <= abs_a_in;
            end
          end
        end
        BUSY: begin
          rem_r  <= rem_nxt;
          quot_r <= quot_nxt;
          cnt    <= cnt - CNT_W'(1);
          if (last_iter) begin
            div_quot    <= sign_q ? -quot_nxt : quot_nxt;
            div_rem     <= sign_r ? -rem_nxt : rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: latency, signed fixup, divide by zero,
// overflow, flush, downstream stall in DONE and reset during BUSY.
module tb_ex_div_ctrl;

  logic        clk;
  logic        reset_n;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        flush_c;
  logic        mem_stall_c;
  logic        div_stall_c;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  ex_div_ctrl #(.DATA_SIZE(32)) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_a       (div_a),
    .div_b       (div_b),
    .flush_c     (flush_c),
    .mem_stall_c (mem_stall_c),
    .div_stall_c (div_stall_c),
    .div_done    (div_done),
    .div_quot    (div_quot),
    .div_rem     (div_rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until div_done; returns the number of
  // stalled cycles before DONE and whether DONE arrived within the budget.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic seen);
    div_signed = sgn;
    div_a      = a;
    div_b      = b;
    div_start  = 1'b1;
    #1;
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (div_done) begin
        seen = 1'b1;
        break;
      end
      if (div_stall_c) stalls++;
      step();
    end
    div_start = 1'b0;
  endtask

  int          stalls;
  logic        seen;
  logic [31:0] q_hold;
  logic [31:0] r_hold;

  initial begin
    reset_n     = 1'b0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_a       = '0;
    div_b       = '0;
    flush_c     = 1'b0;
    mem_stall_c = 1'b0;
    step();
    step();
    check("rst_stall", {31'd0, div_stall_c}, 32'd0);
    check("rst_done",  {31'd0, div_done},    32'd0);
    check("rst_quot",  div_quot,             32'd0);
    check("rst_rem",   div_rem,              32'd0);
    check("rst_bz",    {31'd0, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    step();

    // divu 100 / 7
    run_div(1'b0, 32'd100, 32'd7, stalls, seen);
    check("u_seen",   {31'd0, seen},        32'd1);
    check("u_stalls", stalls,               32'd33);
    check("u_stall_done", {31'd0, div_stall_c}, 32'd0);
    check("u_quot",   div_quot,             32'd14);
    check("u_rem",    div_rem,              32'd2);
    check("u_bz",     {31'd0, div_by_zero}, 32'd0);
    step();
    check("u_idle_done", {31'd0, div_done}, 32'd0);

    // div -7 / 2 and 7 / -2
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, stalls, seen);
    check("s1_seen", {31'd0, seen}, 32'd1);
    check("s1_quot", div_quot, 32'hFFFF_FFFD);
    check("s1_rem",  div_rem,  32'hFFFF_FFFF);
    step();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, stalls, seen);
    check("s2_seen", {31'd0, seen}, 32'd1);
    check("s2_quot", div_quot, 32'hFFFF_FFFD);
    check("s2_rem",  div_rem,  32'd1);
    step();

    // divide by zero
    run_div(1'b1, 32'h1234_5678, 32'd0, stalls, seen);
    check("z_seen",   {31'd0, seen},        32'd1);
    check("z_stalls", stalls,               32'd1);
    check("z_quot",   div_quot,             32'hFFFF_FFFF);
    check("z_rem",    div_rem,              32'h1234_5678);
    check("z_bz",     {31'd0, div_by_zero}, 32'd1);
    step();

    // overflow: -2^31 / -1
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, stalls, seen);
    check("o_seen", {31'd0, seen}, 32'd1);
    check("o_quot", div_quot, 32'h8000_0000);
    check("o_rem",  div_rem,  32'd0);
    check("o_bz",   {31'd0, div_by_zero}, 32'd0);
    step();

    // flush at BUSY cycle 10 of divu 1000 / 3
    div_signed = 1'b0;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_start  = 1'b1;
    step();                          // BUSY cycle 1
    for (int i = 0; i < 9; i++) step();  // BUSY cycle 10
    check("f_busy_stall", {31'd0, div_stall_c}, 32'd1);
    flush_c   = 1'b1;
    div_start = 1'b0;
    #1;
    check("f_stall_low", {31'd0, div_stall_c}, 32'd0);
    step();
    flush_c = 1'b0;
    #1;
    check("f_idle_stall", {31'd0, div_stall_c}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (div_done) seen = 1'b1;
      step();
    end
    check("f_no_done", {31'd0, seen}, 32'd0);
    run_div(1'b0, 32'd9, 32'd3, stalls, seen);
    check("f2_seen",   {31'd0, seen}, 32'd1);
    check("f2_stalls", stalls,        32'd33);
    check("f2_quot",   div_quot,      32'd3);
    check("f2_rem",    div_rem,       32'd0);
    step();

    // mem_stall_c held in DONE for 4 cycles: divu 50 / 6 -> 8 r 2
    mem_stall_c = 1'b1;
    div_signed  = 1'b0;
    div_a       = 32'd50;
    div_b       = 32'd6;
    div_start   = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (div_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("m_seen", {31'd0, seen}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("m_done",  {31'd0, div_done},    32'd1);
      check("m_stall", {31'd0, div_stall_c}, 32'd1);
      check("m_quot",  div_quot,             32'd8);
      check("m_rem",   div_rem,              32'd2);
      if (k < 3) step();
    end
    step();
    mem_stall_c = 1'b0;
    div_start   = 1'b0;
    #1;
    check("m_rel_done",  {31'd0, div_done},    32'd1);
    check("m_rel_stall", {31'd0, div_stall_c}, 32'd0);
    step();
    check("m_idle_done", {31'd0, div_done}, 32'd0);

    // reset during BUSY cycle 5
    div_signed = 1'b0;
    div_a      = 32'd77;
    div_b      = 32'd5;
    div_start  = 1'b1;
    step();                               // BUSY cycle 1
    for (int i = 0; i < 4; i++) step();   // BUSY cycle 5
    reset_n   = 1'b0;
    div_start = 1'b0;
    step();
    check("r_stall", {31'd0, div_stall_c}, 32'd0);
    check("r_done",  {31'd0, div_done},    32'd0);
    check("r_quot",  div_quot,             32'd0);
    check("r_rem",   div_rem,              32'd0);
    check("r_bz",    {31'd0, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    step();
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, stalls, seen);
    check("r2_seen",   {31'd0, seen}, 32'd1);
    check("r2_stalls", stalls,        32'd33);
    check("r2_quot",   div_quot,      32'h0FFF_FFFF);
    check("r2_rem",    div_rem,       32'hF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle divide sequencer for the EX stage. It is the first multi-cycle EX operation.
- Accepts a div request from EX using forwarded operands, runs an iterative restoring divider for DATA_SIZE cycles, and holds the pipeline through ex_stall_c.
- Presents quotient and remainder to the EX result mux and cleanly aborts on a branch/jump flush.

Parameters:
- DATA_SIZE, 32, operand/result width (matches `DATA_SIZE).
- CNT_W, $clog2(DATA_SIZE+1), iteration counter width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- div_start  in  1  EX holds a valid div/divu instruction (ID_EX_op decode, instruc_type != 0)
- div_signed  in  1  1 = div (two's complement), 0 = divu; sampled with div_start
- div_a  in  DATA_SIZE  dividend (forwarded t_A)
- div_b  in  DATA_SIZE  divisor (forwarded t_B)
- flush_c  in  1  EX_MEM_changePC_c; kills the in-flight divide
- mem_stall_c  in  1  downstream stall
- div_stall_c  out  1  OR'd into ex_stall_c
- div_done  out  1  result valid this cycle
- div_quot  out  DATA_SIZE  quotient (LO)
- div_rem  out  DATA_SIZE  remainder (HI)
- div_by_zero  out  1  divisor was zero; qualified by div_done

Behaviour:
- Reset: clock-edge sampled, reset_n=0 → state IDLE, counter 0, all outputs 0 (stall, done, quot, rem, by_zero). Reset mid-divide aborts with no result.
- States:
  - IDLE: on div_start & ~flush_c, latch |a|, |b|, sign_q = signed & (a[MSB]^b[MSB]), sign_r = signed & a[MSB], and zero_div = (b==0).
    - zero_div=1 → DONE.
    - Else → BUSY with counter = DATA_SIZE, partial remainder 0, quotient register = |a|.
  - BUSY: each cycle shift {rem,quot} left by 1; trial = rem_shifted - |b| (DATA_SIZE+1 bits). If trial is non-negative, rem=trial and quot LSB=1; else quot LSB=0. Decrement counter; at counter==1 → DONE.
  - DONE: drive results and div_done=1.
    - mem_stall_c=1 → remain in DONE; outputs held.
    - Else → IDLE. div_start is ignored in DONE because the same instruction is still in ID_EX.
- Result fixup (registered on the IDLE→DONE or BUSY→DONE transition):
  - quot = sign_q ? -q : q.
  - rem = sign_r ? -r : r.
  - Overflow case: -2^(N-1) / -1 gives quot 0x80000000, rem 0 with no special path.
- Divide by zero: quot = all ones; rem = div_a unchanged; div_by_zero=1. Latency is 1 cycle (IDLE→DONE).
- div_stall_c (combinational) = (IDLE & div_start & ~flush_c) | BUSY | (DONE & mem_stall_c).
  - The instruction is held in EX from the accept cycle through the last BUSY cycle.
  - EX registers the result on the DONE cycle with stall low.
- Latency, nonzero divisor: accept cycle T; BUSY T+1..T+DATA_SIZE; DONE at T+DATA_SIZE+1. div_stall_c is high for DATA_SIZE+1 cycles.
- mem_stall_c during BUSY does not pause iteration. The divider finishes and waits in DONE.
- flush_c has priority in every state. On the next edge: IDLE, counter 0, div_done 0. div_stall_c drops combinationally in the same cycle (IDLE term masked; BUSY/DONE are left on the edge).
- Simultaneous div_start and flush_c in IDLE → not accepted.
- div_quot/div_rem hold their last value in IDLE. They are only meaningful while div_done=1.

Test Plan:
- Unsigned divide: divu a=100, b=7 → div_stall_c high exactly 33 cycles; div_done one cycle later with quot=14, rem=2, div_by_zero=0; back in IDLE next cycle.
- Signed fixup: div a=0xFFFFFFF9 (-7), b=2 → quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). Then a=7, b=0xFFFFFFFE → quot=0xFFFFFFFD, rem=1.
- Divide by zero and overflow:
  - div a=0x12345678, b=0 → DONE after 1 cycle; quot=0xFFFFFFFF, rem=0x12345678, div_by_zero=1.
  - div 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rem=0.
- Flush mid-operation: start divu 1000/3, assert flush_c at BUSY cycle 10 → div_stall_c low that cycle, IDLE next edge, no div_done. A new divu 9/3 then yields quot=3, rem=0 with full latency.
- mem_stall in DONE: hold mem_stall_c=1 for 4 cycles on arrival in DONE → div_done, div_stall_c, quot and rem held stable all 4 cycles. div_done drops and state returns to IDLE the cycle after mem_stall_c falls.
- Reset mid-divide: reset_n=0 during BUSY cycle 5 → all outputs 0 on the next edge. After release, divu 0xFFFFFFFF/0x10 → quot=0x0FFFFFFF, rem=0xF.
